// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: pulses the PLL reset, waits for lock, lets lock settle,
// then releases the downstream reset. Timeouts and lock losses are counted.
module pll_lock_monitor #(
    parameter int unsigned PLL_RST_CYCLES = 10,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned SETTLE_CYCLES  = 1000
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       cnt_clr,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic [1:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // Shared counter only needs to reach the largest terminal count.
    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                       : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StSettle   = 2'd2,
        StRun      = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync_q, lock_s;
    logic             retry_inc, loss_inc;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= locked_in;
            lock_s <= sync_q;
        end
    end

    // State, shared counter and event counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= StPllRst;
            cnt_q   <= '0;
            retry_q <= 8'd0;
            loss_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; every transition restarts the shared counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            StPllRst: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d   = StPllRst;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end
            end
            StSettle: begin
                // Loss of lock takes priority over reaching the settle count.
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // Counter is idle while running.
                cnt_d = '0;
                if (!lock_s) begin
                    state_d  = StPllRst;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_comb begin
        retry_d = retry_q;
        loss_d  = loss_q;
        if (cnt_clr) begin
            retry_d = 8'd0;
            loss_d  = 8'd0;
        end else begin
            if (retry_inc && (retry_q != 8'hFF)) begin
                retry_d = retry_q + 8'd1;
            end
            if (loss_inc && (loss_q != 8'hFF)) begin
                loss_d = loss_q + 8'd1;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        state     = state_q;
        pll_rst   = (state_q == StPllRst);
        sys_rst   = (state_q != StRun);
        retry_cnt = retry_q;
        loss_cnt  = loss_q;
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor with small timing parameters.
module tb_pll_lock_monitor;

    localparam int unsigned PRC = 4;
    localparam int unsigned LTO = 20;
    localparam int unsigned SET = 8;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic [1:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       do_rst;
        logic       locked;
        logic       clr;
        logic [1:0] st;
        logic       pll;
        logic       sys;
        logic [7:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl [0:39];

    pll_lock_monitor #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .SETTLE_CYCLES (SET)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked_in(locked_in),
        .cnt_clr  (cnt_clr),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .state    (state),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk = ~refclk;

    function automatic vec_t v(input logic r, input logic l, input logic c, input logic [1:0] s,
                               input logic p, input logic y, input logic [7:0] rc,
                               input logic [7:0] lc);
        vec_t t;
        t.do_rst = r; t.locked = l; t.clr = c; t.st = s;
        t.pll = p; t.sys = y; t.retry = rc; t.loss = lc;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Hold reset over a few edges, check reset outputs, release away from an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst.pll_rst", int'(pll_rst), 1);
        check("rst.sys_rst", int'(sys_rst), 1);
        check("rst.state", int'(state), 0);
        repeat (2) @(posedge refclk);
        #1;
        check("rst.retry", int'(retry_cnt), 0);
        check("rst.loss", int'(loss_cnt), 0);
        @(negedge refclk);
        rst = 1'b0;
    endtask

    // Count edges until sys_rst falls and how many samples had pll_rst high.
    task automatic measure(output int edges, output int pll_hi);
        edges  = 0;
        pll_hi = int'(pll_rst);
        while (sys_rst && edges < 100) begin
            step();
            edges++;
            if (pll_rst) pll_hi++;
        end
        if (sys_rst) edges = -1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int pll_hi;

        // Clean lock from reset: 4 cycles of pll_rst, RUN at edge 13.
        tbl[0] = v(1, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[1] = v(0, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[2] = v(0, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[3] = v(0, 1, 0, 2'd1, 0, 1, 8'd0, 8'd0);
        for (int i = 4; i <= 11; i++) tbl[i] = v(0, 1, 0, 2'd2, 0, 1, 8'd0, 8'd0);
        for (int i = 12; i <= 14; i++) tbl[i] = v(0, 1, 0, 2'd3, 0, 0, 8'd0, 8'd0);
        // Lock drops for 3 cycles at settle count 5: back to WAITLOCK, 8 fresh settle cycles.
        tbl[15] = v(1, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[16] = v(0, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[17] = v(0, 1, 0, 2'd0, 1, 1, 8'd0, 8'd0);
        tbl[18] = v(0, 1, 0, 2'd1, 0, 1, 8'd0, 8'd0);
        for (int i = 19; i <= 24; i++) tbl[i] = v(0, 1, 0, 2'd2, 0, 1, 8'd0, 8'd0);
        tbl[25] = v(0, 0, 0, 2'd2, 0, 1, 8'd0, 8'd0);
        tbl[26] = v(0, 0, 0, 2'd2, 0, 1, 8'd0, 8'd0);
        tbl[27] = v(0, 0, 0, 2'd1, 0, 1, 8'd0, 8'd0);
        tbl[28] = v(0, 1, 0, 2'd1, 0, 1, 8'd0, 8'd0);
        tbl[29] = v(0, 1, 0, 2'd1, 0, 1, 8'd0, 8'd0);
        for (int i = 30; i <= 37; i++) tbl[i] = v(0, 1, 0, 2'd2, 0, 1, 8'd0, 8'd0);
        tbl[38] = v(0, 1, 0, 2'd3, 0, 0, 8'd0, 8'd0);
        tbl[39] = v(0, 1, 0, 2'd3, 0, 0, 8'd0, 8'd0);

        for (int i = 0; i < 40; i++) begin
            locked_in = tbl[i].locked;
            cnt_clr   = tbl[i].clr;
            if (tbl[i].do_rst) do_reset();
            step();
            check($sformatf("vec%0d.state", i), int'(state), int'(tbl[i].st));
            check($sformatf("vec%0d.pll_rst", i), int'(pll_rst), int'(tbl[i].pll));
            check($sformatf("vec%0d.sys_rst", i), int'(sys_rst), int'(tbl[i].sys));
            check($sformatf("vec%0d.retry", i), int'(retry_cnt), int'(tbl[i].retry));
            check($sformatf("vec%0d.loss", i), int'(loss_cnt), int'(tbl[i].loss));
        end
        cnt_clr = 1'b0;

        // Loss of lock in RUN: leaves RUN on the 3rd edge, then relocks with reset timing.
        locked_in = 1'b0;
        step();
        step();
        check("loss.state_edge2", int'(state), 3);
        check("loss.sys_edge2", int'(sys_rst), 0);
        step();
        check("loss.state_edge3", int'(state), 0);
        check("loss.pll_edge3", int'(pll_rst), 1);
        check("loss.sys_edge3", int'(sys_rst), 1);
        check("loss.loss_cnt", int'(loss_cnt), 1);
        locked_in = 1'b1;
        measure(edges, pll_hi);
        check("relock.edges", edges, 13);
        check("relock.pll_cycles", pll_hi, 4);

        // Sub-cycle glitch between edges never reaches the synchronizer.
        #3 locked_in = 1'b0;
        #2 locked_in = 1'b1;
        repeat (4) step();
        check("glitch.state", int'(state), 3);
        check("glitch.loss", int'(loss_cnt), 1);

        // cnt_clr clears the loss counter.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr.loss", int'(loss_cnt), 0);
        check("clr.state", int'(state), 3);

        // Another loss, relock, then asynchronous reset while in RUN.
        locked_in = 1'b0;
        repeat (3) step();
        check("loss2.loss_cnt", int'(loss_cnt), 1);
        locked_in = 1'b1;
        measure(edges, pll_hi);
        check("relock2.edges", edges, 13);
        #3 rst = 1'b1;
        #1;
        check("arst.pll_rst", int'(pll_rst), 1);
        check("arst.sys_rst", int'(sys_rst), 1);
        check("arst.state", int'(state), 0);
        check("arst.loss", int'(loss_cnt), 0);
        @(negedge refclk);
        rst = 1'b0;
        measure(edges, pll_hi);
        check("arst.relock_edges", edges, 13);
        check("arst.pll_cycles", pll_hi, 4);

        // No lock: 24-cycle retry period, retry_cnt saturation, clear on increment edges.
        locked_in = 1'b0;
        do_reset();
        check("to.pll_n0", int'(pll_rst), 1);
        for (int n = 1; n <= 72; n++) begin
            step();
            check($sformatf("to%0d.pll_rst", n), int'(pll_rst), int'((n % 24) < 4));
            check($sformatf("to%0d.retry", n), int'(retry_cnt), n / 24);
            check($sformatf("to%0d.sys_rst", n), int'(sys_rst), 1);
        end
        for (int n = 73; n <= 7200; n++) begin
            step();
            if (n == 6120 || n == 6144) check($sformatf("sat%0d.retry", n), int'(retry_cnt), 255);
        end
        check("sat.retry_final", int'(retry_cnt), 255);
        check("sat.pll_rst", int'(pll_rst), 1);
        for (int n = 7201; n <= 7280; n++) begin
            cnt_clr = (n == 7224 || n == 7272);
            step();
            cnt_clr = 1'b0;
            if (n == 7224) check("clr_sat.retry", int'(retry_cnt), 0);
            if (n == 7248) check("after_clr.retry", int'(retry_cnt), 1);
            if (n == 7272) check("clr_inc.retry", int'(retry_cnt), 0);
            if (n == 7280) check("end.sys_rst", int'(sys_rst), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
